// File: rtl/apb_xip_line_buffer_if.sv
// APB signal bundle shared by the upstream (slave-facing) and downstream
// (master-facing) sides of apb_xip_line_buffer.
//   paddr/psel/penable/pprot/pwrite/pwdata/pstrb : requester -> completer
//   pready/prdata/pslverr                        : completer -> requester
// Modports:
//   master - the side that issues transfers
//   slave  - the side that completes transfers
interface apb_xip_line_buffer_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_xip_line_buffer.sv
// Single-line read buffer in front of the SPI XIP bridge. Reads inside the flash
// window are served from one cached line of LINE_WORDS words; a miss refills the
// whole line with back-to-back downstream reads. Everything else (writes, reads
// outside the window) is forwarded unchanged, one transfer at a time.
// Ports:
//   clock    - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   flush    - invalidate the cached line
//   s_apb    - upstream APB (completer side), pready/prdata/pslverr registered
//   m_apb    - downstream APB (requester side) towards the XIP bridge
module apb_xip_line_buffer #(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    apb_xip_line_buffer_if.slave  s_apb,
    apb_xip_line_buffer_if.master m_apb
);

    localparam int unsigned OFS   = $clog2(LINE_WORDS * 4);
    localparam int unsigned IDX_W = OFS - 2;
    localparam int unsigned TAG_W = 32 - OFS;

    typedef enum logic [2:0] {
        IDLE,
        FILL_SETUP,
        FILL_ACCESS,
        PASS_SETUP,
        PASS_ACCESS,
        RESP
    } state_e;

    state_e                         state_q, state_d;
    logic                           valid_q, valid_d;
    logic                           flush_pend_q, flush_pend_d;
    logic [TAG_W-1:0]               tag_q, tag_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IDX_W-1:0]               word_sel_q, word_sel_d;
    logic [LINE_WORDS-1:0][31:0]    line_q, line_d;
    logic [31:0]                    addr_q, addr_d;
    logic [31:0]                    wdata_q, wdata_d;
    logic [3:0]                     strb_q, strb_d;
    logic [2:0]                     prot_q, prot_d;
    logic                           write_q, write_d;
    logic                           s_pready_q, s_pready_d;
    logic [31:0]                    s_prdata_q, s_prdata_d;
    logic                           s_pslverr_q, s_pslverr_d;

    logic             accept;
    logic             in_window;
    logic             cacheable;
    logic             hit;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_word;
    logic             fill_st;
    logic             pass_st;

    always_comb begin
        accept    = (state_q == IDLE) && s_apb.psel && s_apb.penable && !s_pready_q;
        in_window = (s_apb.paddr >= FLASH_BASE) && (s_apb.paddr <= FLASH_END);
        cacheable = !s_apb.pwrite && in_window;
        req_tag   = s_apb.paddr[31:OFS];
        req_word  = s_apb.paddr[OFS-1:2];
        hit       = cacheable && valid_q && (tag_q == req_tag);
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        word_sel_d   = word_sel_q;
        line_d       = line_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        prot_d       = prot_q;
        write_d      = write_q;
        s_pready_d   = 1'b0;
        s_prdata_d   = '0;
        s_pslverr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    prot_d     = s_apb.pprot;
                    word_sel_d = req_word;
                    if (hit) begin
                        s_pready_d = 1'b1;
                        s_prdata_d = line_q[req_word];
                        state_d    = RESP;
                    end else if (cacheable) begin
                        valid_d = 1'b0;
                        tag_d   = req_tag;
                        idx_d   = '0;
                        state_d = FILL_SETUP;
                    end else begin
                        addr_d  = s_apb.paddr;
                        wdata_d = s_apb.pwdata;
                        strb_d  = s_apb.pstrb;
                        write_d = s_apb.pwrite;
                        // a write into flash may change what the line holds
                        if (in_window) begin
                            valid_d = 1'b0;
                        end
                        state_d = PASS_SETUP;
                    end
                end
            end
            FILL_SETUP: begin
                state_d = FILL_ACCESS;
            end
            FILL_ACCESS: begin
                if (m_apb.pready) begin
                    if (m_apb.pslverr) begin
                        valid_d      = 1'b0;
                        flush_pend_d = 1'b0;
                        s_pready_d   = 1'b1;
                        s_pslverr_d  = 1'b1;
                        state_d      = RESP;
                    end else begin
                        line_d[idx_q] = m_apb.prdata;
                        if (idx_q == IDX_W'(LINE_WORDS - 1)) begin
                            valid_d      = !flush_pend_q;
                            flush_pend_d = 1'b0;
                            s_pready_d   = 1'b1;
                            // line_d so the word arriving on this beat is returned too
                            s_prdata_d   = line_d[word_sel_q];
                            state_d      = RESP;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FILL_SETUP;
                        end
                    end
                end
            end
            PASS_SETUP: begin
                state_d = PASS_ACCESS;
            end
            PASS_ACCESS: begin
                if (m_apb.pready) begin
                    s_pready_d  = 1'b1;
                    s_prdata_d  = m_apb.prdata;
                    s_pslverr_d = m_apb.pslverr;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush that lands while a fill is still running must also cover the
        // words already fetched, so remember it until the fill ends.
        if (flush) begin
            valid_d = 1'b0;
            if ((state_d == FILL_SETUP) || (state_d == FILL_ACCESS)) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            tag_q        <= '0;
            idx_q        <= '0;
            word_sel_q   <= '0;
            line_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            prot_q       <= '0;
            write_q      <= 1'b0;
            s_pready_q   <= 1'b0;
            s_prdata_q   <= '0;
            s_pslverr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            word_sel_q   <= word_sel_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            prot_q       <= prot_d;
            write_q      <= write_d;
            s_pready_q   <= s_pready_d;
            s_prdata_q   <= s_prdata_d;
            s_pslverr_q  <= s_pslverr_d;
        end
    end

    // Downstream signals decode straight from the state register so an
    // asynchronous reset drops psel/penable immediately.
    always_comb begin
        fill_st       = (state_q == FILL_SETUP) || (state_q == FILL_ACCESS);
        pass_st       = (state_q == PASS_SETUP) || (state_q == PASS_ACCESS);
        m_apb.psel    = fill_st || pass_st;
        m_apb.penable = (state_q == FILL_ACCESS) || (state_q == PASS_ACCESS);
        m_apb.pprot   = (fill_st || pass_st) ? prot_q : '0;
        m_apb.pwrite  = pass_st && write_q;
        m_apb.pwdata  = pass_st ? wdata_q : '0;
        m_apb.pstrb   = (pass_st && write_q) ? strb_q : '0;
        if (fill_st) begin
            m_apb.paddr = {tag_q, idx_q, 2'b00};
        end else if (pass_st) begin
            m_apb.paddr = addr_q;
        end else begin
            m_apb.paddr = '0;
        end
    end

    assign s_apb.pready  = s_pready_q;
    assign s_apb.prdata  = s_prdata_q;
    assign s_apb.pslverr = s_pslverr_q;

endmodule

// File: tb/tb_apb_xip_line_buffer.sv
module tb_apb_xip_line_buffer;

    logic clock;
    logic reset_n;
    logic flush;

    apb_xip_line_buffer_if s_if ();
    apb_xip_line_buffer_if m_if ();

    apb_xip_line_buffer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .s_apb   (s_if),
        .m_apb   (m_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] err_addr = 32'hffff_ffff;

    logic [31:0] mon_addr[$];
    logic [31:0] mon_wdata[$];
    logic [3:0]  mon_strb[$];
    logic [2:0]  mon_prot[$];
    logic        mon_write[$];
    int          psel_cycles;

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hdead_beef;
    endfunction

    // zero-wait downstream flash model
    assign m_if.pready  = m_if.psel && m_if.penable;
    assign m_if.prdata  = model_word(m_if.paddr);
    assign m_if.pslverr = m_if.psel && m_if.penable && (m_if.paddr == err_addr);

    always @(negedge clock) begin
        if (m_if.psel) psel_cycles++;
        if (m_if.psel && m_if.penable && m_if.pready) begin
            mon_addr.push_back(m_if.paddr);
            mon_wdata.push_back(m_if.pwdata);
            mon_strb.push_back(m_if.pstrb);
            mon_prot.push_back(m_if.pprot);
            mon_write.push_back(m_if.pwrite);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rd, output logic er, output int lat);
        int k;
        mon_addr.delete();
        mon_wdata.delete();
        mon_strb.delete();
        mon_prot.delete();
        mon_write.delete();
        psel_cycles = 0;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        @(posedge clock);
        #1;
        s_if.paddr   = addr;
        s_if.pwrite  = wr;
        s_if.pwdata  = wd;
        s_if.pstrb   = strb;
        s_if.pprot   = prot;
        s_if.psel    = 1'b1;
        s_if.penable = 1'b0;
        @(posedge clock);
        #1;
        s_if.penable = 1'b1;
        k = 0;
        while (k < 100) begin
            @(negedge clock);
            k++;
            if (s_if.pready === 1'b1) break;
        end
        if (s_if.pready === 1'b1) begin
            rd  = s_if.prdata;
            er  = s_if.pslverr;
            lat = k - 1;
        end else begin
            check("pready_timeout", 32'd0, 32'd1);
        end
        @(posedge clock);
        #1;
        s_if.psel    = 1'b0;
        s_if.penable = 1'b0;
    endtask

    task automatic check_fill(input string tag, input logic [31:0] base);
        check({tag, "_beats"}, mon_addr.size(), 4);
        for (int i = 0; i < mon_addr.size(); i++) begin
            check({tag, "_addr"}, mon_addr[i], base + 32'(4 * i));
            check({tag, "_rd"}, {31'd0, mon_write[i]}, 32'd0);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        reset_n      = 1'b0;
        flush        = 1'b0;
        s_if.paddr   = '0;
        s_if.psel    = 1'b0;
        s_if.penable = 1'b0;
        s_if.pprot   = '0;
        s_if.pwrite  = 1'b0;
        s_if.pwdata  = '0;
        s_if.pstrb   = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_s_pready", {31'd0, s_if.pready}, 32'd0);
        check("rst_s_prdata", s_if.prdata, 32'd0);
        check("rst_m_psel", {31'd0, m_if.psel}, 32'd0);
        check("rst_m_penable", {31'd0, m_if.penable}, 32'd0);
        check("rst_m_paddr", m_if.paddr, 32'd0);
        reset_n = 1'b1;

        // 1: cold read
        apb_xfer(32'h3000_0008, 1'b0, '0, 4'hf, 3'b100, rd, er, lat);
        check_fill("cold", 32'h3000_0000);
        check("cold_data", rd, 32'heead_bee7);
        check("cold_err", {31'd0, er}, 32'd0);
        check("cold_lat", lat, 9);
        check("cold_psel_cont", psel_cycles, 8);
        if (mon_prot.size() > 0) check("cold_prot", {29'd0, mon_prot[0]}, 32'd4);
        if (mon_strb.size() > 0) check("cold_strb", {28'd0, mon_strb[0]}, 32'd0);

        // 2: hits
        apb_xfer(32'h3000_0004, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check("hit1_data", rd, model_word(32'h3000_0004));
        check("hit1_lat", lat, 1);
        check("hit1_psel", psel_cycles, 0);
        apb_xfer(32'h3000_000c, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check("hit3_data", rd, model_word(32'h3000_000c));
        check("hit3_lat", lat, 1);

        // 3: line replacement
        apb_xfer(32'h3000_0010, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("repl", 32'h3000_0010);
        check("repl_data", rd, model_word(32'h3000_0010));
        apb_xfer(32'h3000_0000, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("back", 32'h3000_0000);
        check("back_data", rd, model_word(32'h3000_0000));

        // 4: pass-through
        apb_xfer(32'h1000_1010, 1'b0, '0, 4'h0, 3'b101, rd, er, lat);
        check("pr_beats", mon_addr.size(), 1);
        if (mon_addr.size() > 0) begin
            check("pr_addr", mon_addr[0], 32'h1000_1010);
            check("pr_prot", {29'd0, mon_prot[0]}, 32'd5);
            check("pr_write", {31'd0, mon_write[0]}, 32'd0);
        end
        check("pr_data", rd, model_word(32'h1000_1010));
        check("pr_lat", lat, 3);
        apb_xfer(32'h1000_1018, 1'b1, 32'h1, 4'b0011, 3'b000, rd, er, lat);
        check("pw_beats", mon_addr.size(), 1);
        if (mon_addr.size() > 0) begin
            check("pw_addr", mon_addr[0], 32'h1000_1018);
            check("pw_wdata", mon_wdata[0], 32'h1);
            check("pw_strb", {28'd0, mon_strb[0]}, 32'd3);
            check("pw_write", {31'd0, mon_write[0]}, 32'd1);
        end
        check("pw_rdata", rd, model_word(32'h1000_1018));
        apb_xfer(32'h3000_0008, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check("after_pass_hit_beats", mon_addr.size(), 0);
        check("after_pass_hit_data", rd, model_word(32'h3000_0008));

        // window boundaries
        apb_xfer(32'h3fff_fffc, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("top", 32'h3fff_fff0);
        check("top_data", rd, model_word(32'h3fff_fffc));
        apb_xfer(32'h4000_0000, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check("above_beats", mon_addr.size(), 1);
        apb_xfer(32'h2fff_fffc, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check("below_beats", mon_addr.size(), 1);
        check("below_data", rd, model_word(32'h2fff_fffc));
        apb_xfer(32'h3000_0004, 1'b1, 32'h55, 4'hf, 3'b000, rd, er, lat);
        check("fw_beats", mon_addr.size(), 1);
        if (mon_strb.size() > 0) check("fw_strb", {28'd0, mon_strb[0]}, 32'hf);
        apb_xfer(32'h3fff_fff8, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("fw_inval", 32'h3fff_fff0);

        // 5: error on fill beat 2
        err_addr = 32'h3000_0104;
        apb_xfer(32'h3000_0108, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check("err_slverr", {31'd0, er}, 32'd1);
        check("err_rdata", rd, 32'd0);
        check("err_beats", mon_addr.size(), 2);
        err_addr = 32'hffff_ffff;
        apb_xfer(32'h3000_0108, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("err_retry", 32'h3000_0100);
        check("err_retry_data", rd, model_word(32'h3000_0108));
        check("err_retry_err", {31'd0, er}, 32'd0);

        // 6: flush during fill beat 1
        fork
            apb_xfer(32'h3000_0208, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
            begin
                repeat (3) @(posedge clock);
                #1 flush = 1'b1;
                @(posedge clock);
                #1 flush = 1'b0;
            end
        join
        check_fill("fl_fill", 32'h3000_0200);
        check("fl_fill_data", rd, model_word(32'h3000_0208));
        apb_xfer(32'h3000_0208, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("fl_reread", 32'h3000_0200);

        // flush while idle
        @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        apb_xfer(32'h3000_0204, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("fl_idle", 32'h3000_0200);

        // flush coinciding with a hit
        fork
            apb_xfer(32'h3000_020c, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
            begin
                repeat (2) @(posedge clock);
                #1 flush = 1'b1;
                @(posedge clock);
                #1 flush = 1'b0;
            end
        join
        check("fl_hit_beats", mon_addr.size(), 0);
        check("fl_hit_data", rd, model_word(32'h3000_020c));
        apb_xfer(32'h3000_020c, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("fl_hit_reread", 32'h3000_0200);

        // reset in the middle of a fill
        @(posedge clock);
        #1;
        s_if.paddr   = 32'h3000_0400;
        s_if.pwrite  = 1'b0;
        s_if.psel    = 1'b1;
        s_if.penable = 1'b0;
        @(posedge clock);
        #1 s_if.penable = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("midfill_psel", {31'd0, m_if.psel}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_psel", {31'd0, m_if.psel}, 32'd0);
        check("rst_async_penable", {31'd0, m_if.penable}, 32'd0);
        check("rst_async_pready", {31'd0, s_if.pready}, 32'd0);
        @(posedge clock);
        #1;
        s_if.psel    = 1'b0;
        s_if.penable = 1'b0;
        reset_n      = 1'b1;
        apb_xfer(32'h3000_0400, 1'b0, '0, 4'h0, 3'b000, rd, er, lat);
        check_fill("post_rst", 32'h3000_0400);
        check("post_rst_data", rd, model_word(32'h3000_0400));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
